// File: rtl/dac_pkg.sv
// Shared definitions for the LTC2624 waveform sequencer: command/address codes,
// waveform selector encodings and the layout of the 32-bit DAC command word.
package dac_pkg;

    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;
    localparam logic [3:0] CMD_NOP          = 4'b1111;

    localparam logic [3:0] ADDR_A   = 4'd0;
    localparam logic [3:0] ADDR_B   = 4'd1;
    localparam logic [3:0] ADDR_C   = 4'd2;
    localparam logic [3:0] ADDR_D   = 4'd3;
    localparam logic [3:0] ADDR_ALL = 4'b1111;

    typedef enum logic [1:0] {
        WAVE_RAMP     = 2'b00,
        WAVE_TRIANGLE = 2'b01,
        WAVE_SQUARE   = 2'b10,
        WAVE_DC       = 2'b11
    } wave_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } seq_state_e;

    localparam int CMD_LSB  = 20;
    localparam int ADDR_LSB = 16;
    localparam int DATA_LSB = 4;

    // Leading byte and trailing nibble are don't-care padding for the DAC; keep them zero.
    function automatic logic [31:0] build_word(input logic [3:0]  cmd,
                                               input logic [3:0]  addr,
                                               input logic [11:0] data);
        logic [31:0] w;
        w                  = '0;
        w[CMD_LSB  +: 4]   = cmd;
        w[ADDR_LSB +: 4]   = addr;
        w[DATA_LSB +: 12]  = data;
        return w;
    endfunction

endpackage

// File: rtl/dac_wave_sequencer_tick_divider.sv
// Sample-rate timer: counts 0..DIV-1 while enabled and pulses o_tick on the
// wrapping cycle; disabling holds the count at zero.
module dac_tick_divider #(
    parameter int unsigned DIV = 5000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic i_enable,
    output logic o_tick
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] r_count;
    logic        w_wrap;

    assign w_wrap = (r_count == LAST);
    assign o_tick = i_enable && w_wrap;

    always_ff @(posedge CLOCK) begin
        if (RESET || !i_enable) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: rtl/dac_wave_sequencer.sv
// Rate-controlled waveform source for the LTC2624 serializer: one 12-bit sample
// per tick, emitted as one command word per enabled channel over valid/ready.
module dac_wave_sequencer
    import dac_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 5000,
    parameter logic [11:0] STEP       = 12'd16,
    parameter logic [3:0]  DAC_CMD    = CMD_WRITE_UPDATE
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [1:0]  WAVE_SEL,
    input  logic [11:0] LEVEL,
    input  logic [3:0]  CHAN_MASK,
    output logic [31:0] WORD,
    output logic        WORD_VALID,
    input  logic        WORD_READY,
    output logic [11:0] SAMPLE,
    output logic        BUSY,
    output logic [7:0]  OVERRUN_COUNT
);

    seq_state_e  r_state;
    seq_state_e  w_state_next;
    logic [3:0]  r_mask;
    logic [11:0] r_sample;
    logic        r_dir_down;
    logic        r_sq_high;
    logic [31:0] r_word;
    logic        r_valid;
    logic [7:0]  r_overrun;

    logic        w_tick;
    logic        w_hs;
    logic [1:0]  w_lowest;
    logic [3:0]  w_lowest_onehot;
    logic [12:0] w_sum;
    logic [11:0] w_sample_next;
    logic        w_dir_next;
    logic        w_sq_next;

    dac_tick_divider #(.DIV(SAMPLE_DIV)) u_tick (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .i_enable (ENABLE),
        .o_tick   (w_tick)
    );

    assign w_hs = r_valid && WORD_READY;

    always_comb begin
        w_lowest = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_mask[i]) w_lowest = 2'(i);
        end
        w_lowest_onehot = 4'b0001 << w_lowest;
    end

    // Triangle math runs in 13 bits so the upper clamp sees the true sum.
    always_comb begin
        w_sample_next = r_sample;
        w_dir_next    = r_dir_down;
        w_sq_next     = r_sq_high;
        w_sum         = {1'b0, r_sample} + {1'b0, STEP};
        case (wave_sel_e'(WAVE_SEL))
            WAVE_RAMP: w_sample_next = w_sum[11:0];
            WAVE_TRIANGLE: begin
                if (!r_dir_down) begin
                    if (w_sum >= 13'd4095) begin
                        w_sample_next = 12'd4095;
                        w_dir_next    = 1'b1;
                    end else begin
                        w_sample_next = w_sum[11:0];
                    end
                end else if (r_sample <= STEP) begin
                    w_sample_next = 12'd0;
                    w_dir_next    = 1'b0;
                end else begin
                    w_sample_next = r_sample - STEP;
                end
            end
            WAVE_SQUARE: begin
                w_sample_next = r_sq_high ? LEVEL : 12'd0;
                w_sq_next     = !r_sq_high;
            end
            WAVE_DC: w_sample_next = LEVEL;
            default: w_sample_next = r_sample;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_tick && (CHAN_MASK != 4'b0000)) w_state_next = ST_EMIT;
            ST_EMIT: if (w_hs && ((r_mask & ~w_lowest_onehot) == 4'b0000)) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_mask     <= '0;
            r_sample   <= '0;
            r_dir_down <= 1'b0;
            r_sq_high  <= 1'b1;
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= '0;
        end else begin
            if (w_tick) begin
                if (r_state == ST_IDLE) begin
                    r_sample   <= w_sample_next;
                    r_dir_down <= w_dir_next;
                    r_sq_high  <= w_sq_next;
                    r_mask     <= CHAN_MASK;
                end else if (r_overrun != 8'hFF) begin
                    r_overrun <= r_overrun + 8'd1;
                end
            end
            // Load the next word while idle on the bus, retire it on handshake.
            if (r_state == ST_EMIT) begin
                if (!r_valid) begin
                    r_word  <= build_word(DAC_CMD, {2'b00, w_lowest}, r_sample);
                    r_valid <= 1'b1;
                end else if (WORD_READY) begin
                    r_valid <= 1'b0;
                    r_mask  <= r_mask & ~w_lowest_onehot;
                end
            end
        end
    end

    assign WORD          = r_word;
    assign WORD_VALID    = r_valid;
    assign SAMPLE        = r_sample;
    assign BUSY          = (r_state != ST_IDLE);
    assign OVERRUN_COUNT = r_overrun;

endmodule

// File: tb/tb_dac_wave_sequencer.sv
// Bench for dac_wave_sequencer: two instances (STEP 16 and 2047) driven in
// lockstep and compared against a per-tick behavioural waveform/word model.
module tb_dac_wave_sequencer;

    localparam int DIV    = 8;
    localparam int STEP_A = 16;
    localparam int STEP_B = 2047;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic [1:0]  WAVE_SEL;
    logic [11:0] LEVEL;
    logic [3:0]  CHAN_MASK;
    logic        WORD_READY;

    logic [31:0] word_a, word_b;
    logic        valid_a, valid_b;
    logic [11:0] sample_a, sample_b;
    logic        busy_a, busy_b;
    logic [7:0]  ovr_a, ovr_b;

    int checks = 0;
    int errors = 0;

    int          m_timer;
    int          m_sample [2];
    bit          m_down   [2];
    bit          m_sq_high[2];
    logic [31:0] exp_q[$];
    logic [31:0] seen[$];

    always #5 CLOCK = ~CLOCK;

    dac_wave_sequencer #(.SAMPLE_DIV(DIV), .STEP(12'd16), .DAC_CMD(4'b0011)) dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .WAVE_SEL(WAVE_SEL),
        .LEVEL(LEVEL), .CHAN_MASK(CHAN_MASK), .WORD(word_a), .WORD_VALID(valid_a),
        .WORD_READY(WORD_READY), .SAMPLE(sample_a), .BUSY(busy_a), .OVERRUN_COUNT(ovr_a)
    );

    dac_wave_sequencer #(.SAMPLE_DIV(DIV), .STEP(12'd2047), .DAC_CMD(4'b0011)) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .WAVE_SEL(WAVE_SEL),
        .LEVEL(LEVEL), .CHAN_MASK(CHAN_MASK), .WORD(word_b), .WORD_VALID(valid_b),
        .WORD_READY(WORD_READY), .SAMPLE(sample_b), .BUSY(busy_b), .OVERRUN_COUNT(ovr_b)
    );

    task automatic model_reset();
        m_timer = 0;
        for (int i = 0; i < 2; i++) begin
            m_sample[i]  = 0;
            m_down[i]    = 1'b0;
            m_sq_high[i] = 1'b1;
        end
        exp_q.delete();
        seen.delete();
    endtask

    task automatic advance(input int i, input int st);
        int s;
        s = m_sample[i];
        case (WAVE_SEL)
            2'd0: s = (s + st) % 4096;
            2'd1: begin
                if (!m_down[i]) begin
                    if (s + st >= 4095) begin s = 4095; m_down[i] = 1'b1; end
                    else s = s + st;
                end else begin
                    if (s <= st) begin s = 0; m_down[i] = 1'b0; end
                    else s = s - st;
                end
            end
            2'd2: begin
                s = m_sq_high[i] ? int'(LEVEL) : 0;
                m_sq_high[i] = !m_sq_high[i];
            end
            default: s = int'(LEVEL);
        endcase
        m_sample[i] = s;
    endtask

    // Model of one clock cycle with the inputs currently driven.
    task automatic step_model();
        if (!ENABLE) begin
            m_timer = 0;
        end else if (m_timer == DIV - 1) begin
            m_timer = 0;
            advance(0, STEP_A);
            advance(1, STEP_B);
            for (int n = 0; n < 4; n++)
                if (CHAN_MASK[n])
                    exp_q.push_back(32'h0030_0000 | (32'(n) << 16) | (32'(m_sample[0]) << 4));
        end else begin
            m_timer = m_timer + 1;
        end
    endtask

    task automatic run(input int n);
        logic [31:0] exp_w;
        repeat (n) begin
            step_model();
            @(negedge CLOCK);
            checks++;
            if (sample_a !== 12'(m_sample[0])) begin
                errors++;
                $display("FAIL sample_a got %0d want %0d", sample_a, m_sample[0]);
            end
            checks++;
            if (sample_b !== 12'(m_sample[1])) begin
                errors++;
                $display("FAIL sample_b got %0d want %0d", sample_b, m_sample[1]);
            end
            if (valid_a && WORD_READY) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got %h want none", word_a);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (word_a !== exp_w) begin
                        errors++;
                        $display("FAIL word got %h want %h", word_a, exp_w);
                    end
                end
                seen.push_back(word_a);
            end
        end
    endtask

    task automatic do_reset();
        RESET      = 1'b1;
        ENABLE     = 1'b0;
        WORD_READY = 1'b1;
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (word_a !== 32'h0)  begin errors++; $display("FAIL rst_word got %h want 0", word_a); end
        checks++; if (valid_a !== 1'b0)  begin errors++; $display("FAIL rst_valid got %b want 0", valid_a); end
        checks++; if (sample_a !== 12'h0) begin errors++; $display("FAIL rst_sample got %h want 0", sample_a); end
        checks++; if (busy_a !== 1'b0)   begin errors++; $display("FAIL rst_busy got %b want 0", busy_a); end
        checks++; if (ovr_a !== 8'h0)    begin errors++; $display("FAIL rst_overrun got %0d want 0", ovr_a); end
    endtask

    task automatic test_ramp();
        do_reset();
        WAVE_SEL = 2'b00; CHAN_MASK = 4'b0001; ENABLE = 1'b1;
        run(DIV * 257);
        checks++;
        if (seen.size() < 256) begin
            errors++;
            $display("FAIL ramp_word_count got %0d want >=256", seen.size());
        end else begin
            checks++; if (seen[0] !== 32'h0030_0100)   begin errors++; $display("FAIL ramp_w0 got %h want 00300100", seen[0]); end
            checks++; if (seen[1] !== 32'h0030_0200)   begin errors++; $display("FAIL ramp_w1 got %h want 00300200", seen[1]); end
            checks++; if (seen[254] !== 32'h0030_FF00) begin errors++; $display("FAIL ramp_4080 got %h want 0030ff00", seen[254]); end
            checks++; if (seen[255] !== 32'h0030_0000) begin errors++; $display("FAIL ramp_wrap got %h want 00300000", seen[255]); end
        end
        checks++; if (sample_a !== 12'd16) begin errors++; $display("FAIL ramp_after_wrap got %0d want 16", sample_a); end
    endtask

    task automatic test_triangle();
        do_reset();
        WAVE_SEL = 2'b01; CHAN_MASK = 4'b0001; ENABLE = 1'b1;
        run(DIV * 3);
        checks++; if (sample_b !== 12'd4095) begin errors++; $display("FAIL tri_top got %0d want 4095", sample_b); end
        run(DIV * 3);
        checks++; if (sample_b !== 12'd0)    begin errors++; $display("FAIL tri_bottom got %0d want 0", sample_b); end
        run(DIV);
        checks++; if (sample_b !== 12'd2047) begin errors++; $display("FAIL tri_restart got %0d want 2047", sample_b); end
        run(DIV * 40);
    endtask

    task automatic test_multi_channel();
        do_reset();
        WAVE_SEL = 2'b11; LEVEL = 12'hABC; CHAN_MASK = 4'b1011; ENABLE = 1'b1;
        run(DIV);
        seen.delete();
        CHAN_MASK = 4'b0100;
        run(6);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL multi_busy got %b want 0", busy_a); end
        checks++;
        if (seen.size() != 3) begin
            errors++;
            $display("FAIL multi_count got %0d want 3", seen.size());
        end else begin
            checks++; if (seen[0] !== 32'h0030_ABC0) begin errors++; $display("FAIL multi_w0 got %h want 0030abc0", seen[0]); end
            checks++; if (seen[1] !== 32'h0031_ABC0) begin errors++; $display("FAIL multi_w1 got %h want 0031abc0", seen[1]); end
            checks++; if (seen[2] !== 32'h0033_ABC0) begin errors++; $display("FAIL multi_w2 got %h want 0033abc0", seen[2]); end
        end
        run(DIV * 2);
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int          waited;
        do_reset();
        WAVE_SEL = 2'b00; CHAN_MASK = 4'b0001; WORD_READY = 1'b0; ENABLE = 1'b1;
        waited = 0;
        while (!valid_a && waited < 20) begin
            @(negedge CLOCK);
            waited++;
        end
        checks++;
        if (!valid_a) begin
            errors++;
            $display("FAIL bp_valid_timeout got 0 want 1");
            return;
        end
        held = word_a;
        checks++; if (held !== 32'h0030_0100) begin errors++; $display("FAIL bp_word got %h want 00300100", held); end
        repeat (18) begin
            @(negedge CLOCK);
            checks++;
            if (!valid_a || word_a !== held) begin
                errors++;
                $display("FAIL bp_stable got %b/%h want 1/%h", valid_a, word_a, held);
            end
        end
        checks++; if (ovr_a !== 8'd2)     begin errors++; $display("FAIL bp_overrun got %0d want 2", ovr_a); end
        checks++; if (sample_a !== 12'd16) begin errors++; $display("FAIL bp_sample got %0d want 16", sample_a); end
        repeat (DIV * 260) @(negedge CLOCK);
        checks++; if (ovr_a !== 8'd255) begin errors++; $display("FAIL bp_saturate got %0d want 255", ovr_a); end
        checks++;
        if (!valid_a || word_a !== held) begin
            errors++;
            $display("FAIL bp_long_stable got %b/%h want 1/%h", valid_a, word_a, held);
        end
        WORD_READY = 1'b1;
        @(negedge CLOCK);
        checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL bp_release got %b/%b want 0/0", valid_a, busy_a); end
        repeat (9) @(negedge CLOCK);
        checks++; if (sample_a !== 12'd32) begin errors++; $display("FAIL bp_resume got %0d want 32", sample_a); end
        checks++; if (ovr_a !== 8'd255)    begin errors++; $display("FAIL bp_ovr_hold got %0d want 255", ovr_a); end
    endtask

    task automatic test_square_no_mask();
        do_reset();
        WAVE_SEL = 2'b10; LEVEL = 12'h800; CHAN_MASK = 4'b0000; ENABLE = 1'b1;
        run(DIV);
        checks++; if (sample_a !== 12'h800) begin errors++; $display("FAIL sq_high got %h want 800", sample_a); end
        run(DIV);
        checks++; if (sample_a !== 12'h000) begin errors++; $display("FAIL sq_low got %h want 000", sample_a); end
        run(DIV * 6);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL sq_busy got %b want 0", busy_a); end
    endtask

    task automatic test_reset_mid_emit();
        int waited;
        do_reset();
        WAVE_SEL = 2'b11; LEVEL = 12'h123; CHAN_MASK = 4'b0001; WORD_READY = 1'b0; ENABLE = 1'b1;
        waited = 0;
        while (!valid_a && waited < 30) begin
            @(negedge CLOCK);
            waited++;
        end
        checks++;
        if (!valid_a) begin
            errors++;
            $display("FAIL rme_valid_timeout got 0 want 1");
        end
        RESET = 1'b1;
        @(negedge CLOCK);
        checks++; if (valid_a !== 1'b0)   begin errors++; $display("FAIL rme_valid got %b want 0", valid_a); end
        checks++; if (sample_a !== 12'h0) begin errors++; $display("FAIL rme_sample got %h want 0", sample_a); end
        checks++; if (ovr_a !== 8'h0)     begin errors++; $display("FAIL rme_overrun got %0d want 0", ovr_a); end
        checks++; if (busy_a !== 1'b0)    begin errors++; $display("FAIL rme_busy got %b want 0", busy_a); end
        checks++; if (word_a !== 32'h0)   begin errors++; $display("FAIL rme_word got %h want 0", word_a); end
        RESET = 1'b0; ENABLE = 1'b0; WORD_READY = 1'b1;
        model_reset();
        run(40);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL disabled_busy got %b want 0", busy_a); end
    endtask

    task automatic test_random();
        logic [3:0] m;
        do_reset();
        ENABLE = 1'b1; WORD_READY = 1'b1;
        WAVE_SEL = 2'b00; LEVEL = 12'h0; CHAN_MASK = 4'b0001;
        for (int c = 0; c < 1200; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                WAVE_SEL = 2'($urandom_range(0, 3));
                LEVEL    = 12'($urandom_range(0, 4095));
                m        = 4'($urandom_range(0, 15));
                CHAN_MASK = (m == 4'hF) ? 4'h7 : m;
            end
            if ($urandom_range(0, 31) == 0) ENABLE = !ENABLE;
            run(1);
        end
        checks++; if (ovr_a !== 8'd0) begin errors++; $display("FAIL rand_overrun_a got %0d want 0", ovr_a); end
        checks++; if (ovr_b !== 8'd0) begin errors++; $display("FAIL rand_overrun_b got %0d want 0", ovr_b); end
    endtask

    initial begin
        RESET = 1'b1; ENABLE = 1'b0; WAVE_SEL = 2'b00; LEVEL = 12'h0;
        CHAN_MASK = 4'b0000; WORD_READY = 1'b1;
        model_reset();
        test_reset();
        test_ramp();
        test_triangle();
        test_multi_channel();
        test_backpressure();
        test_square_no_mask();
        test_reset_mid_emit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
